montinvp2: RTL
==============

Name: montinvp2

Overview:
- Phase-2 correction stage of the Montgomery inverse. Sits directly downstream of the phase-1 almost-inverse unit.
- Consumes the phase-1 result ain = a^-1 * 2^exp mod p and its exponent exp. Produces res = a^-1 * 2^tgt mod p by performing (exp - tgt) modular halvings, one per clock.
- Use tgt = WIDTH for a Montgomery-domain inverse, or tgt = 0 for a plain modular inverse.

Parameters:
- WIDTH, 256, operand/modulus width in bits.
- CWID, 10, width of exponent and iteration counter.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- en, input, 1, start strobe; one-cycle pulse, driven by phase-1 vld.
- ain, input, WIDTH, almost-inverse value; sampled when en=1.
- exp, input, CWID, exponent k from phase 1; sampled when en=1.
- mod, input, WIDTH, odd modulus p; sampled when en=1.
- tgt, input, CWID, target exponent; sampled when en=1.
- res, output, WIDTH, corrected inverse; valid when vld=1, held until the next en.
- vld, output, 1, one-cycle completion pulse.
- busy, output, 1, high while a job is in progress.
- err, output, 1, qualified by vld: set when exp < tgt.

Behaviour:
- Reset (async, any time including mid-job):
  - res=0, vld=0, busy=0, err=0, state=IDLE.
  - Internal r, p and cnt cleared.
- States: IDLE, LOAD, HALVE.
- IDLE:
  - vld=0.
  - On en: latch p<=mod, r<=ain; compute cnt<=exp-tgt as a CWID+1-bit signed difference; busy<=1; go to LOAD.
- LOAD (one cycle):
  - If r >= p then r<=r-p (single conditional subtract covers phase-1 outputs in [p,2p)); otherwise r is unchanged.
  - If the difference is negative (exp < tgt): err<=1, res<=0, vld<=1, busy<=0; go to IDLE.
  - Else if cnt==0: res<=reduced r, vld<=1, err<=0, busy<=0; go to IDLE.
  - Else go to HALVE.
- HALVE (one step per cycle):
  - If r[0]==0 then r<=r>>1; else r<=(r+p)>>1.
  - The sum is computed at WIDTH+1 bits so the carry lands in r[WIDTH-1]. No overflow is possible since r<p.
  - cnt<=cnt-1.
  - On the step where cnt==1: res<=halved value, vld<=1, err<=0, busy<=0; go to IDLE.
- Invariant: r < p after LOAD and after every halving step.
- Latency:
  - With N = exp - tgt >= 0, vld is high in the cycle following edge E0+1+N, where E0 is the edge that samples en.
  - Error case: vld after E0+1.
- vld:
  - Exactly one cycle per accepted job.
  - Never asserted for an aborted job.
  - res only updates in the same edge that sets vld.
- en while busy:
  - Abort the current job and restart with the new operands, behaving exactly as en in IDLE.
  - res keeps its previous value until the new job completes.
- en in the same cycle as vld: the new job is accepted; the vld pulse for the finished job still occurs.
- exp == tgt: no halving; result is ain reduced once mod p.
- mod is assumed odd and nonzero by contract. Behaviour for even p is unspecified, but the FSM must still terminate after N steps.

Test Plan:
- WIDTH=8, p=11, ain=7, exp=5, tgt=0 -> r sequence 9,10,5,8,4; res=4, err=0; vld after edge E0+6 only; busy high for 6 cycles.
- Same operands with tgt=2 -> res=5 (4*4 mod 11); vld after edge E0+4.
- WIDTH=8, p=251, ain=249, exp=1, tgt=0 -> odd path with carry into bit 8; res=250.
- WIDTH=8, p=11, ain=15, exp=1, tgt=0 -> LOAD reduces to 4, res=2; second case ain=4, exp=tgt=3 -> res=4, vld after E0+1.
- exp=3, tgt=5 -> vld with err=1, res=0 after E0+1; the next valid job clears err.
- Abort and reset:
  - Start the first job from the tgt=0 scenario, then pulse en two cycles later with ain=3, exp=1, tgt=0, p=11 -> only one vld occurs, with res=7.
  - Assert rst mid-HALVE -> all outputs 0 immediately (asynchronous), no vld after rst is released.

Source files
------------

// File: rtl/montinvp2.sv
// Montgomery inverse, phase 2: turns a*2^exp mod p into a*2^tgt mod p
// by one conditional subtract followed by (exp - tgt) modular halvings.
module montinvp2 #(
    parameter int WIDTH = 256,
    parameter int CWID  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] ain,
    input  logic [CWID-1:0]  exp,
    input  logic [WIDTH-1:0] mod,
    input  logic [CWID-1:0]  tgt,
    output logic [WIDTH-1:0] res,
    output logic             vld,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] HALVE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] p;
    logic [CWID:0]    cnt;

    logic [CWID:0]    cnt_init;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r_red;
    logic [WIDTH-1:0] r_half;
    logic             cnt_neg;
    logic             cnt_zero;
    logic             cnt_one;

    // Both operands are unsigned CWID bits, so the extra bit is a true sign.
    assign cnt_init = {1'b0, exp} - {1'b0, tgt};

    assign diff  = {1'b0, r} - {1'b0, p};
    assign r_red = diff[WIDTH] ? r : diff[WIDTH-1:0];

    // The carry of r+p becomes the top bit of the halved value.
    assign sum    = {1'b0, r} + {1'b0, p};
    assign r_half = r[0] ? sum[WIDTH:1] : {1'b0, r[WIDTH-1:1]};

    assign cnt_neg  = cnt[CWID];
    assign cnt_zero = (cnt == '0);
    assign cnt_one  = (cnt == {{CWID{1'b0}}, 1'b1});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
            p     <= '0;
            cnt   <= '0;
            res   <= '0;
            vld   <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            vld <= 1'b0;
            if (en) begin
                // A new strobe always wins, aborting any job in flight.
                p     <= mod;
                r     <= ain;
                cnt   <= cnt_init;
                busy  <= 1'b1;
                state <= LOAD;
            end else begin
                case (state)
                    LOAD: begin
                        r <= r_red;
                        if (cnt_neg) begin
                            err   <= 1'b1;
                            res   <= '0;
                            vld   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (cnt_zero) begin
                            err   <= 1'b0;
                            res   <= r_red;
                            vld   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= HALVE;
                        end
                    end
                    HALVE: begin
                        r   <= r_half;
                        cnt <= cnt - 1'b1;
                        if (cnt_one) begin
                            err   <= 1'b0;
                            res   <= r_half;
                            vld   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
